sdram_model: RTL and testbench
==============================

Name: sdram_model

Overview:
Synthesizable responder-side SDRAM device model: the far end of the SDRAM pin interface driven by `sdram_ctrl`. It decodes commands, tracks per-bank open rows, holds a mode register and serves sequential bursts from a small on-chip array. It honours the programmed CAS latency, burst length and DQM byte masking, and flags protocol violations. It replaces the external chip in controller simulations and FPGA loopback builds.

Parameters:
ROW_WIDTH, 13, row address width (`a_i` width)
COL_WIDTH, 9, column width; full-page burst length = 2^COL_WIDTH
BA_WIDTH, 2, bank address width
MEM_ADDR_WIDTH, 14, storage depth 2^MEM_ADDR_WIDTH words; address = low bits of {ba,row,col}

Ports:
sdram_clk  in  1  clock; all state on rising edge
sdram_rst  in  1  synchronous active-high reset
cke_i  in  1  clock enable; 0 = suspend
cs_n_i  in  1  chip select, active low
ras_n_i  in  1  row strobe, active low
cas_n_i  in  1  column strobe, active low
we_n_i  in  1  write enable, active low
ba_i  in  BA_WIDTH  bank address
a_i  in  ROW_WIDTH  row/column/mode address; a_i[10] = all-banks on PRECHARGE
dqm_i  in  2  write byte mask; [1] = upper byte, [0] = lower byte
dq_i  in  16  write data (controller dq_o)
dq_o  out  16  read data
dq_oe_o  out  1  1 while a read beat is driven
err_o  out  1  sticky protocol-violation flag

Behaviour:
- Command sampled at edge N only when cke_i=1 and cs_n_i=0; otherwise NOP. Decode {ras,cas,we}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 110 BURST STOP, 010 PRECHARGE, 001 REFRESH, 000 LOAD MODE.
- cke_i=0: no command decoded; burst counter and read pipeline hold; dq_o/dq_oe_o hold.
- Reset: all banks closed, mode = BL 1 / CL 2, no burst, dq_oe_o=0, dq_o=0, err_o=0. Memory contents are not cleared.
- LOAD MODE: a_i[2:0] BL (000=1, 001=2, 010=4, 011=8, 111=full page); a_i[6:4] CL (010=2, 011=3). Other BL/CL values: err_o=1, mode unchanged. LOAD MODE with any bank open also sets err_o.
- ACT: open_row[ba]=a_i, bank marked open. ACT to an already-open bank: err_o=1, row replaced.
- PRECHARGE: closes bank ba_i, or all banks if a_i[10]=1. Terminates any burst to a closed bank; read beats already in the pipeline still emerge.
- REFRESH: no data effect. Any bank open: err_o=1.
- READ/WRITE to a closed bank: err_o=1, command ignored.
- Column = a_i[COL_WIDTH-1:0]. Burst beat k address: low log2(BL) column bits = (start+k) mod BL, upper bits fixed (wrap inside aligned block). Full page: wrap at 2^COL_WIDTH, runs until BURST STOP, PRECHARGE or a new READ/WRITE.
- READ at edge N: beat k sampled by the controller at edge N+CL+k. Model registers the beat at edge N+CL-1+k; dq_oe_o=1 over the same span, otherwise 0. Read pipeline depth is 3; DQM does not affect reads.
- WRITE at edge N: beat 0 taken from dq_i at edge N, beat k at N+k. A byte is written only when its dqm_i bit is 0.
- A new READ/WRITE/BURST STOP aborts the current burst immediately. Read beats already scheduled still emerge, but the new READ's beats take priority on overlap.
- READ issued while a write burst runs: write stops; no bus contention check.
- err_o cleared only by sdram_rst.
- sdram_rst mid-burst: at the next edge, burst aborted, pipeline flushed, dq_oe_o=0.

Test Plan:
- LOAD MODE 0x022 (BL 4, CL 2); ACT ba1 row 5; WRITE col 0, data 0x1000..0x1003; READ col 0 at edge N -> dq_o 0x1000..0x1003 sampled at N+2..N+5, dq_oe_o=1 only then, err_o=0.
- BL 4, CL 3; READ col 6 of the written block -> data order col 6,7,4,5 sampled at N+3..N+6.
- WRITE 0xFFFF to col 8 with dqm_i=2'b10 after pre-writing 0x1234 -> readback 0x12FF.
- READ to closed bank 2 -> err_o=1 at the next edge, dq_oe_o stays 0; err_o holds until sdram_rst.
- Full-page READ col 510, BURST STOP issued 4 edges later -> cols 510,511,0,1 only, then dq_oe_o=0.
- sdram_rst asserted during an 8-beat read -> dq_oe_o=0 next edge; subsequent READ without ACT -> err_o=1.

Source files
------------

// File: rtl/sdram_model.sv
// Responder-side SDRAM device model: command decode, per-bank open rows, mode
// register, CL/BL-accurate sequential bursts, DQM byte masking, sticky error flag.
module sdram_model #(
  parameter int unsigned ROW_WIDTH      = 13,
  parameter int unsigned COL_WIDTH      = 9,
  parameter int unsigned BA_WIDTH       = 2,
  parameter int unsigned MEM_ADDR_WIDTH = 14
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_rst,
  input  logic                 cke_i,
  input  logic                 cs_n_i,
  input  logic                 ras_n_i,
  input  logic                 cas_n_i,
  input  logic                 we_n_i,
  input  logic [BA_WIDTH-1:0]  ba_i,
  input  logic [ROW_WIDTH-1:0] a_i,
  input  logic [1:0]           dqm_i,
  input  logic [15:0]          dq_i,
  output logic [15:0]          dq_o,
  output logic                 dq_oe_o,
  output logic                 err_o
);
  localparam int unsigned NUM_BANKS  = 1 << BA_WIDTH;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned MEM_DEPTH  = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  // Beat-offset mask for a burst-length code; full page wraps over the whole row.
  function automatic logic [COL_WIDTH-1:0] bl_mask(input logic [2:0] bl);
    case (bl)
      3'b001:  return COL_WIDTH'(1);
      3'b010:  return COL_WIDTH'(3);
      3'b011:  return COL_WIDTH'(7);
      3'b111:  return '1;
      default: return '0;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [NUM_BANKS-1:0]                bank_open_q, bank_open_d;
  logic [NUM_BANKS-1:0][ROW_WIDTH-1:0] open_row_q, open_row_d;
  logic [2:0]                          bl_q, bl_d;
  logic                                cl3_q, cl3_d;
  logic                                err_q, err_d;
  logic                                burst_act_q, burst_act_d;
  logic                                burst_rd_q, burst_rd_d;
  logic                                burst_full_q, burst_full_d;
  logic [BA_WIDTH-1:0]                 burst_ba_q, burst_ba_d;
  logic [ROW_WIDTH-1:0]                burst_row_q, burst_row_d;
  logic [COL_WIDTH-1:0]                burst_col_q, burst_col_d;
  logic [COL_WIDTH-1:0]                burst_cnt_q, burst_cnt_d;
  logic [COL_WIDTH-1:0]                burst_mask_q, burst_mask_d;
  logic [1:0]                          pipe_vld_q, pipe_vld_d;
  logic [1:0][DATA_WIDTH-1:0]          pipe_dat_q, pipe_dat_d;
  logic [DATA_WIDTH-1:0]               dq_q, dq_d;
  logic                                dq_oe_q, dq_oe_d;

  cmd_e                  cmd_c;
  logic                  beat_go_c, beat_rd_c, wr_en_c;
  logic [BA_WIDTH-1:0]   beat_ba_c;
  logic [ROW_WIDTH-1:0]  beat_row_c;
  logic [COL_WIDTH-1:0]  beat_col_c;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_c;

  always_comb begin
    bank_open_d  = bank_open_q;
    open_row_d   = open_row_q;
    bl_d         = bl_q;
    cl3_d        = cl3_q;
    err_d        = err_q;
    burst_act_d  = burst_act_q;
    burst_rd_d   = burst_rd_q;
    burst_full_d = burst_full_q;
    burst_ba_d   = burst_ba_q;
    burst_row_d  = burst_row_q;
    burst_col_d  = burst_col_q;
    burst_cnt_d  = burst_cnt_q;
    burst_mask_d = burst_mask_q;
    pipe_vld_d   = pipe_vld_q;
    pipe_dat_d   = pipe_dat_q;
    dq_d         = dq_q;
    dq_oe_d      = dq_oe_q;
    cmd_c        = CMD_NOP;
    beat_go_c    = 1'b0;
    beat_rd_c    = burst_rd_q;
    beat_ba_c    = burst_ba_q;
    beat_row_c   = burst_row_q;
    beat_col_c   = (burst_col_q & ~burst_mask_q) | ((burst_col_q + burst_cnt_q) & burst_mask_q);
    wr_en_c      = 1'b0;

    if (cke_i) begin
      cmd_c      = cs_n_i ? CMD_NOP : cmd_e'({ras_n_i, cas_n_i, we_n_i});
      dq_oe_d    = pipe_vld_q[0];
      if (pipe_vld_q[0]) dq_d = pipe_dat_q[0];
      pipe_vld_d    = {1'b0, pipe_vld_q[1]};
      pipe_dat_d[0] = pipe_dat_q[1];
      if (burst_act_q) begin
        beat_go_c   = 1'b1;
        burst_cnt_d = burst_cnt_q + COL_WIDTH'(1);
        if (!burst_full_q && burst_cnt_q == burst_mask_q) burst_act_d = 1'b0;
      end
    end

    case (cmd_c)
      CMD_LMR: begin
        if (|bank_open_q) err_d = 1'b1;
        if ((a_i[2:0] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111}) &&
            (a_i[6:4] inside {3'b010, 3'b011})) begin
          bl_d  = a_i[2:0];
          cl3_d = a_i[4];
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_REF: if (|bank_open_q) err_d = 1'b1;
      CMD_ACT: begin
        if (bank_open_q[ba_i]) err_d = 1'b1;
        bank_open_d[ba_i] = 1'b1;
        open_row_d[ba_i]  = a_i;
      end
      CMD_PRE: begin
        if (a_i[10]) bank_open_d = '0;
        else         bank_open_d[ba_i] = 1'b0;
        if (burst_act_q && (a_i[10] || ba_i == burst_ba_q)) begin
          beat_go_c   = 1'b0;
          burst_act_d = 1'b0;
        end
      end
      CMD_BST: begin
        beat_go_c   = 1'b0;
        burst_act_d = 1'b0;
      end
      CMD_RD, CMD_WR: begin
        if (!bank_open_q[ba_i]) begin
          err_d = 1'b1;
        end else begin
          // Beat 0 is served on the command edge; the burst registers cover beats 1..BL-1.
          beat_go_c    = 1'b1;
          beat_rd_c    = (cmd_c == CMD_RD);
          beat_ba_c    = ba_i;
          beat_row_c   = open_row_q[ba_i];
          beat_col_c   = a_i[COL_WIDTH-1:0];
          burst_act_d  = (bl_q != 3'b000);
          burst_rd_d   = (cmd_c == CMD_RD);
          burst_ba_d   = ba_i;
          burst_row_d  = open_row_q[ba_i];
          burst_col_d  = a_i[COL_WIDTH-1:0];
          burst_cnt_d  = COL_WIDTH'(1);
          burst_mask_d = bl_mask(bl_q);
          burst_full_d = (bl_q == 3'b111);
        end
      end
      default: ;
    endcase

    mem_addr_c = MEM_ADDR_WIDTH'({beat_ba_c, beat_row_c, beat_col_c});
    // Read beats enter the pipeline so they reach dq_o CL-1 edges after the fetch.
    if (beat_go_c) begin
      if (beat_rd_c) begin
        if (cl3_q) begin
          pipe_vld_d[1] = 1'b1;
          pipe_dat_d[1] = mem_q[mem_addr_c];
        end else begin
          pipe_vld_d[0] = 1'b1;
          pipe_dat_d[0] = mem_q[mem_addr_c];
        end
      end else begin
        wr_en_c = 1'b1;
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      bank_open_q  <= '0;
      open_row_q   <= '0;
      bl_q         <= 3'b000;
      cl3_q        <= 1'b0;
      err_q        <= 1'b0;
      burst_act_q  <= 1'b0;
      burst_rd_q   <= 1'b0;
      burst_full_q <= 1'b0;
      burst_ba_q   <= '0;
      burst_row_q  <= '0;
      burst_col_q  <= '0;
      burst_cnt_q  <= '0;
      burst_mask_q <= '0;
      pipe_vld_q   <= '0;
      pipe_dat_q   <= '0;
      dq_q         <= '0;
      dq_oe_q      <= 1'b0;
    end else begin
      bank_open_q  <= bank_open_d;
      open_row_q   <= open_row_d;
      bl_q         <= bl_d;
      cl3_q        <= cl3_d;
      err_q        <= err_d;
      burst_act_q  <= burst_act_d;
      burst_rd_q   <= burst_rd_d;
      burst_full_q <= burst_full_d;
      burst_ba_q   <= burst_ba_d;
      burst_row_q  <= burst_row_d;
      burst_col_q  <= burst_col_d;
      burst_cnt_q  <= burst_cnt_d;
      burst_mask_q <= burst_mask_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_dat_q   <= pipe_dat_d;
      dq_q         <= dq_d;
      dq_oe_q      <= dq_oe_d;
    end
  end

  // Storage survives reset; each byte lane is written only when its mask bit is low.
  always_ff @(posedge sdram_clk) begin
    if (wr_en_c && !sdram_rst) begin
      if (!dqm_i[0]) mem_q[mem_addr_c][7:0]  <= dq_i[7:0];
      if (!dqm_i[1]) mem_q[mem_addr_c][15:8] <= dq_i[15:8];
    end
  end

  assign dq_o    = dq_q;
  assign dq_oe_o = dq_oe_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_sdram_model.sv
// Bench for sdram_model: directed scenarios plus randomized command traffic,
// checked every cycle against a queue-based behavioural device model.
module tb_sdram_model;
  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst = 1'b1;
  logic        cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = '0;
  logic [12:0] a = '0;
  logic [1:0]  dqm = 2'b11;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe, err;

  always #5 sdram_clk = ~sdram_clk;

  sdram_model dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .cke_i(cke), .cs_n_i(cs_n),
    .ras_n_i(ras_n), .cas_n_i(cas_n), .we_n_i(we_n), .ba_i(ba), .a_i(a),
    .dqm_i(dqm), .dq_i(dq_in), .dq_o(dq_out), .dq_oe_o(dq_oe), .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: whole burst expanded into a beat queue at command time.
  typedef struct { bit rd; int addr; } beat_t;
  logic [15:0] m_mem [int];
  bit          m_open [4];
  int          m_row [4];
  int          m_bl, m_cl, m_qbank, m_t;
  bit          m_err;
  beat_t       m_q [$];
  bit          exp_oe [int];
  logic [15:0] exp_dq [int];

  task automatic model_reset();
    foreach (m_open[i]) m_open[i] = 1'b0;
    m_bl = 1; m_cl = 2; m_err = 1'b0;
    m_q.delete(); exp_oe.delete(); exp_dq.delete();
  endtask

  task automatic model_edge();
    int cl_now, len, start, col, addr, bl_new, cl_new;
    bit any_open;
    beat_t b;
    logic [15:0] cur;
    if (sdram_rst) begin model_reset(); return; end
    if (!cke) return;
    m_t++;
    cl_now = m_cl;
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        C_ACT: begin
          if (m_open[ba]) m_err = 1'b1;
          m_open[ba] = 1'b1; m_row[ba] = int'(a);
        end
        C_RD, C_WR: begin
          if (!m_open[ba]) m_err = 1'b1;
          else begin
            m_q.delete(); m_qbank = int'(ba);
            start = int'(a) % 512;
            len = (m_bl == 512) ? 1024 : m_bl;
            for (int k = 0; k < len; k++) begin
              col  = (start / m_bl) * m_bl + (start + k) % m_bl;
              addr = (int'(ba) * (1 << 22) + m_row[ba] * 512 + col) % 16384;
              b.rd = (we_n == 1'b1); b.addr = addr;
              m_q.push_back(b);
            end
          end
        end
        C_BST: m_q.delete();
        C_PRE: begin
          if (a[10]) begin
            foreach (m_open[i]) m_open[i] = 1'b0;
            m_q.delete();
          end else begin
            m_open[ba] = 1'b0;
            if (int'(ba) == m_qbank) m_q.delete();
          end
        end
        C_REF: if (any_open) m_err = 1'b1;
        C_LMR: begin
          if (any_open) m_err = 1'b1;
          case (a[2:0])
            3'd0: bl_new = 1;  3'd1: bl_new = 2;  3'd2: bl_new = 4;
            3'd3: bl_new = 8;  3'd7: bl_new = 512; default: bl_new = -1;
          endcase
          cl_new = (a[6:4] == 3'd2) ? 2 : (a[6:4] == 3'd3) ? 3 : -1;
          if (bl_new > 0 && cl_new > 0) begin m_bl = bl_new; m_cl = cl_new; end
          else m_err = 1'b1;
        end
        default: ;
      endcase
    end
    if (m_q.size() > 0) begin
      b = m_q.pop_front();
      if (b.rd) begin
        exp_oe[m_t + cl_now - 1] = 1'b1;
        if (m_mem.exists(b.addr)) exp_dq[m_t + cl_now - 1] = m_mem[b.addr];
        else exp_dq.delete(m_t + cl_now - 1);
      end else if (dqm == 2'b00) begin
        m_mem[b.addr] = dq_in;
      end else if (m_mem.exists(b.addr)) begin
        cur = m_mem[b.addr];
        if (!dqm[0]) cur[7:0]  = dq_in[7:0];
        if (!dqm[1]) cur[15:8] = dq_in[15:8];
        m_mem[b.addr] = cur;
      end
    end
  endtask

  task automatic step();
    bit eo;
    @(posedge sdram_clk);
    model_edge();
    @(negedge sdram_clk);
    eo = exp_oe.exists(m_t);
    check($sformatf("dq_oe@%0d", m_t), 32'(dq_oe), 32'(eo));
    check($sformatf("err@%0d", m_t), 32'(err), 32'(m_err));
    if (eo && exp_dq.exists(m_t)) check($sformatf("dq@%0d", m_t), 32'(dq_out), 32'(exp_dq[m_t]));
  endtask

  task automatic issue(input logic [2:0] c, input int b, input int addr,
                       input logic [15:0] d, input logic [1:0] m);
    cke = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = c;
    ba = 2'(b); a = 13'(addr); dq_in = d; dqm = m;
    step();
  endtask

  logic [15:0] rd_seen [$];
  int          first_oe;

  // NOPs (or a BURST STOP at index stop_at), recording every driven read beat.
  task automatic run_collect(input int n, input int stop_at);
    rd_seen.delete(); first_oe = -1;
    for (int i = 1; i <= n; i++) begin
      issue((i == stop_at) ? C_BST : C_NOP, 0, 0, 16'h0, 2'b11);
      if (dq_oe) begin
        if (first_oe < 0) first_oe = i;
        rd_seen.push_back(dq_out);
      end
    end
  endtask

  task automatic expect_beats(input string tag, input int first, input logic [15:0] v0,
                              input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] ev [4];
    ev[0] = v0; ev[1] = v1; ev[2] = v2; ev[3] = v3;
    check({tag, "_first"}, 32'(first_oe), 32'(first));
    check({tag, "_len"}, 32'(rd_seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_beat%0d", tag, i), 32'((i < rd_seen.size()) ? rd_seen[i] : 16'hDEAD), 32'(ev[i]));
  endtask

  int bl_codes [5] = '{0, 1, 2, 3, 7};

  initial begin
    int r;
    logic [2:0] op;
    int addr_r;
    model_reset();
    m_t = 0; m_qbank = 0;
    @(negedge sdram_clk);
    step(); step();
    check("rst_dq", 32'(dq_out), 32'h0);
    check("rst_oe", 32'(dq_oe), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    sdram_rst = 1'b0;

    // BL4 CL2 write then read back
    issue(C_LMR, 0, 'h022, 0, 2'b11);
    issue(C_ACT, 1, 5, 0, 2'b11);
    issue(C_WR, 1, 0, 16'h1000, 2'b00);
    issue(C_NOP, 0, 0, 16'h1001, 2'b00);
    issue(C_NOP, 0, 0, 16'h1002, 2'b00);
    issue(C_NOP, 0, 0, 16'h1003, 2'b00);
    issue(C_WR, 1, 4, 16'h1004, 2'b00);
    issue(C_NOP, 0, 0, 16'h1005, 2'b00);
    issue(C_NOP, 0, 0, 16'h1006, 2'b00);
    issue(C_NOP, 0, 0, 16'h1007, 2'b00);
    issue(C_RD, 1, 0, 0, 2'b11);
    run_collect(6, 0);
    expect_beats("bl4cl2", 1, 16'h1000, 16'h1001, 16'h1002, 16'h1003);
    check("bl4cl2_err", 32'(err), 32'h0);

    // BL4 CL3, wrapped start column
    issue(C_PRE, 0, 'h400, 0, 2'b11);
    issue(C_LMR, 0, 'h032, 0, 2'b11);
    issue(C_ACT, 1, 5, 0, 2'b11);
    issue(C_RD, 1, 6, 0, 2'b11);
    run_collect(7, 0);
    expect_beats("wrap_cl3", 2, 16'h1006, 16'h1007, 16'h1004, 16'h1005);

    // Byte-masked write
    issue(C_WR, 1, 8, 16'h1234, 2'b00);
    repeat (3) issue(C_NOP, 0, 0, 16'h5555, 2'b11);
    issue(C_WR, 1, 8, 16'hFFFF, 2'b10);
    repeat (3) issue(C_NOP, 0, 0, 16'h5555, 2'b11);
    issue(C_RD, 1, 8, 0, 2'b11);
    run_collect(7, 0);
    check("dqm_len", 32'(rd_seen.size()), 32'd4);
    check("dqm_beat0", 32'((rd_seen.size() > 0) ? rd_seen[0] : 16'hDEAD), 32'h12FF);

    // Full-page read across the row end, cut by BURST STOP
    issue(C_PRE, 0, 'h400, 0, 2'b11);
    issue(C_LMR, 0, 'h027, 0, 2'b11);
    issue(C_ACT, 1, 5, 0, 2'b11);
    issue(C_WR, 1, 510, 16'hA510, 2'b00);
    issue(C_NOP, 0, 0, 16'hA511, 2'b00);
    issue(C_BST, 0, 0, 0, 2'b11);
    issue(C_RD, 1, 510, 0, 2'b11);
    run_collect(10, 4);
    expect_beats("fullpage", 1, 16'hA510, 16'hA511, 16'h1000, 16'h1001);

    // Read to a closed bank
    issue(C_RD, 2, 0, 0, 2'b11);
    check("closed_err", 32'(err), 32'h1);
    check("closed_oe", 32'(dq_oe), 32'h0);
    repeat (3) issue(C_NOP, 0, 0, 0, 2'b11);
    check("closed_err_sticky", 32'(err), 32'h1);

    // Reset in the middle of an 8-beat read
    sdram_rst = 1'b1; step(); sdram_rst = 1'b0;
    issue(C_LMR, 0, 'h023, 0, 2'b11);
    issue(C_ACT, 0, 3, 0, 2'b11);
    issue(C_RD, 0, 0, 0, 2'b11);
    repeat (3) issue(C_NOP, 0, 0, 0, 2'b11);
    check("midrst_oe_before", 32'(dq_oe), 32'h1);
    sdram_rst = 1'b1;
    issue(C_NOP, 0, 0, 0, 2'b11);
    sdram_rst = 1'b0;
    check("midrst_oe", 32'(dq_oe), 32'h0);
    check("midrst_err_clr", 32'(err), 32'h0);
    issue(C_RD, 0, 0, 0, 2'b11);
    check("rd_no_act_err", 32'(err), 32'h1);
    repeat (4) issue(C_NOP, 0, 0, 0, 2'b11);

    // Randomized traffic
    sdram_rst = 1'b1; step(); sdram_rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      sdram_rst = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 99);
      if      (r < 25) op = C_NOP;
      else if (r < 40) op = C_ACT;
      else if (r < 60) op = C_RD;
      else if (r < 78) op = C_WR;
      else if (r < 83) op = C_BST;
      else if (r < 93) op = C_PRE;
      else if (r < 95) op = C_REF;
      else             op = C_LMR;
      case (op)
        C_ACT:       addr_r = $urandom_range(0, 1);
        C_RD, C_WR:  addr_r = ($urandom_range(0, 7) == 0) ? $urandom_range(500, 511) : $urandom_range(0, 15);
        C_PRE:       addr_r = $urandom_range(0, 1) << 10;
        C_LMR:       addr_r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127)
                              : (($urandom_range(2, 3) << 4) | bl_codes[$urandom_range(0, 4)]);
        default:     addr_r = $urandom_range(0, 8191);
      endcase
      cke = ($urandom_range(0, 9) != 0);
      cs_n = ($urandom_range(0, 9) == 0);
      {ras_n, cas_n, we_n} = op;
      ba = 2'($urandom_range(0, 3));
      a = 13'(addr_r);
      dq_in = 16'($urandom);
      dqm = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
